// File: rtl/img_buf_pkg.sv
// Shared types and sizing helpers for the ping-pong image buffer.
package img_buf_pkg;

  localparam int PIXEL_W = 16;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_SWAP = 2'd1,
    SWAP      = 2'd2
  } load_state_t;

  function automatic int calc_depth(input int width, input int height, input int images);
    return width * height * images;
  endfunction

  function automatic int calc_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pingpong_load_ctrl.sv
// Loader/arbiter in front of the ping-pong image BRAM: fills the inactive bank
// from a valid/ready pixel stream and swaps banks once the consumer lets go.
module pingpong_load_ctrl
  import img_buf_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_IMAGES    = 4,
  parameter int IMAGE_WIDTH   = 64,
  parameter int IMAGE_HEIGHT  = 64,
  parameter int PRELOAD_BANK0 = 1,
  localparam int DEPTH = calc_depth(IMAGE_WIDTH, IMAGE_HEIGHT, NUM_IMAGES),
  localparam int AW    = calc_aw(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  bank_sel,
  output logic                  write_en,
  output logic [AW-1:0]         addr_in_0,
  output logic [AW-1:0]         addr_in_1,
  output logic [DATA_WIDTH-1:0] wdata_0,
  output logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  rd_bank_valid,
  input  logic                  rd_done,
  output logic                  swap_pulse,
  output logic                  err_len
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic          PRELOAD   = (PRELOAD_BANK0 != 0);

  load_state_t           state_r;
  logic [AW-1:0]         wr_addr_r;
  logic [AW-1:0]         addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  accept_s;

  assign s_ready   = (state_r == FILL);
  assign accept_s  = s_valid & s_ready;
  assign addr_in_0 = addr_r;
  assign addr_in_1 = addr_r;
  assign wdata_0   = wdata_r;
  assign wdata_1   = wdata_r;

  // Load FSM with address counter, write register and bank ownership.
  // The swap is only taken from WAIT_SWAP, so the final write (presented in the
  // first WAIT_SWAP cycle) is always captured under the old bank_sel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= FILL;
      wr_addr_r     <= {AW{1'b0}};
      addr_r        <= {AW{1'b0}};
      wdata_r       <= {DATA_WIDTH{1'b0}};
      write_en      <= 1'b0;
      bank_sel      <= 1'b0;
      swap_pulse    <= 1'b0;
      err_len       <= 1'b0;
      rd_bank_valid <= PRELOAD;
    end else begin
      write_en   <= 1'b0;
      swap_pulse <= 1'b0;
      case (state_r)
        FILL: begin
          if (rd_done) begin
            rd_bank_valid <= 1'b0;
          end
          if (accept_s) begin
            write_en <= 1'b1;
            addr_r   <= wr_addr_r;
            wdata_r  <= s_data;
            if ((wr_addr_r == LAST_ADDR) || s_last) begin
              wr_addr_r <= {AW{1'b0}};
              state_r   <= WAIT_SWAP;
              if (s_last && (wr_addr_r != LAST_ADDR)) begin
                err_len <= 1'b1;
              end
            end else begin
              wr_addr_r <= wr_addr_r + AW'(1);
            end
          end
        end
        WAIT_SWAP: begin
          if (!rd_bank_valid || rd_done) begin
            state_r       <= SWAP;
            bank_sel      <= ~bank_sel;
            swap_pulse    <= 1'b1;
            rd_bank_valid <= 1'b1;
          end
        end
        SWAP: begin
          state_r <= FILL;
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_load_ctrl.sv
// Directed bench for pingpong_load_ctrl (2x2x2 images, DEPTH=8) with a write scoreboard.
module tb_pingpong_load_ctrl;
  import img_buf_pkg::*;

  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  pixel_t        s_data;
  logic          s_last;
  logic          bank_sel;
  logic          write_en;
  logic [AW-1:0] addr_in_0;
  logic [AW-1:0] addr_in_1;
  pixel_t        wdata_0;
  pixel_t        wdata_1;
  logic          rd_bank_valid;
  logic          rd_done;
  logic          swap_pulse;
  logic          err_len;

  pingpong_load_ctrl #(
    .DATA_WIDTH(16), .NUM_IMAGES(2), .IMAGE_WIDTH(2), .IMAGE_HEIGHT(2), .PRELOAD_BANK0(1)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .bank_sel(bank_sel), .write_en(write_en), .addr_in_0(addr_in_0),
    .addr_in_1(addr_in_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .rd_bank_valid(rd_bank_valid), .rd_done(rd_done), .swap_pulse(swap_pulse),
    .err_len(err_len)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    pixel_t        d;
    logic [31:0]   cyc;
  } exp_t;

  exp_t    q[$];
  exp_t    mon_e;
  pixel_t  bank0 [8];
  pixel_t  bank1 [8];
  int      vectors = 0;
  int      errors  = 0;
  int      cyc     = 0;
  int      wr_cnt  = 0;
  int      acc_cnt = 0;
  int      exp_addr = 0;
  logic    last_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // BRAM model: bank_sel=0 writes bank1, bank_sel=1 writes bank0.
  always @(posedge clk) begin
    if (write_en === 1'b1) begin
      if (bank_sel) bank0[addr_in_0] <= wdata_0;
      else          bank1[addr_in_0] <= wdata_0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every write must match the oldest accepted beat, one cycle later.
  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      wr_cnt++;
      if (q.size() == 0) begin
        chk("wr_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("wr_addr0", 32'(addr_in_0), 32'(mon_e.a));
        chk("wr_addr1", 32'(addr_in_1), 32'(mon_e.a));
        chk("wr_data0", 32'(wdata_0), 32'(mon_e.d));
        chk("wr_data1", 32'(wdata_1), 32'(mon_e.d));
        chk("wr_latency", 32'(cyc), mon_e.cyc + 32'd1);
      end
      chk("wr_in_swap", 32'(swap_pulse), 32'd0);
    end
  end

  task automatic drive(input logic v, input pixel_t d, input logic l, input logic done);
    @(posedge clk);
    #1;
    s_valid = v;
    s_data  = d;
    s_last  = l;
    rd_done = done;
    last_acc = v && s_ready;
    if (last_acc) begin
      q.push_back('{a: AW'(exp_addr), d: d, cyc: 32'(cyc)});
      acc_cnt++;
      exp_addr = (exp_addr == 7 || l) ? 0 : exp_addr + 1;
    end
  endtask

  task automatic send(input pixel_t d, input logic l, input logic done);
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      drive(1'b1, d, l, done);
      ok = last_acc;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; s_valid = 1'b0; s_data = 16'h0000; s_last = 1'b0; rd_done = 1'b0;
    for (int i = 0; i < 8; i++) begin bank0[i] = 16'h0000; bank1[i] = 16'h0000; end
    repeat (2) @(posedge clk);
    #1;
    // T1 reset state
    chk("rst_valid", 32'(rd_bank_valid), 32'd1);
    chk("rst_bank_sel", 32'(bank_sel), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h0010 + 16'(i), i == 7, 1'b0);
    // T2 no rd_done: hold in WAIT_SWAP
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t2_s_ready", 32'(s_ready), 32'd0);
      chk("t2_bank_sel", 32'(bank_sel), 32'd0);
    end
    chk("t2_bank1_7", 32'(bank1[7]), 32'h17);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    idle();
    chk("t2_swap_pulse", 32'(swap_pulse), 32'd1);
    chk("t2_bank_sel", 32'(bank_sel), 32'd1);
    chk("t2_valid", 32'(rd_bank_valid), 32'd1);
    idle();
    chk("t2_swap_end", 32'(swap_pulse), 32'd0);
    chk("t2_refill", 32'(s_ready), 32'd1);
    // T3 rd_done during fill
    for (int i = 0; i < 8; i++) begin
      send(16'h0020 + 16'(i), i == 7, i == 3);
      if (i == 4) chk("t3_valid_drop", 32'(rd_bank_valid), 32'd0);
    end
    idle();
    chk("t3_last_we", 32'(write_en), 32'd1);
    chk("t3_last_addr", 32'(addr_in_0), 32'd7);
    chk("t3_old_bank", 32'(bank_sel), 32'd1);
    chk("t3_no_swap_yet", 32'(swap_pulse), 32'd0);
    idle();
    chk("t3_swap", 32'(swap_pulse), 32'd1);
    chk("t3_bank_sel", 32'(bank_sel), 32'd0);
    chk("t3_we_off", 32'(write_en), 32'd0);
    chk("t3_valid", 32'(rd_bank_valid), 32'd1);
    chk("t3_bank0_7", 32'(bank0[7]), 32'h27);
    chk("t3_bank1_7", 32'(bank1[7]), 32'h17);
    idle();
    // T4 early s_last
    for (int i = 0; i < 5; i++) send(16'h0030 + 16'(i), i == 4, 1'b0);
    idle();
    chk("t4_err_len", 32'(err_len), 32'd1);
    chk("t4_wait", 32'(s_ready), 32'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    idle();
    chk("t4_swap", 32'(swap_pulse), 32'd1);
    chk("t4_bank_sel", 32'(bank_sel), 32'd1);
    idle();
    chk("t4_sticky", 32'(err_len), 32'd1);
    // T5 random s_valid
    n = 0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      drive(1'($urandom_range(0, 1)), 16'h0040 + 16'(n), n == 7, 1'b0);
      if (last_acc) n++;
    end
    chk("t5_accepts", 32'(n), 32'd8);
    idle();
    chk("t5_sticky", 32'(err_len), 32'd1);
    chk("t5_wait", 32'(s_ready), 32'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    idle();
    chk("t5_swap", 32'(swap_pulse), 32'd1);
    idle();
    chk("t5_wr_vs_acc", 32'(wr_cnt), 32'(acc_cnt));
    // T6 async reset mid-fill
    for (int i = 0; i < 3; i++) send(16'h0050 + 16'(i), 1'b0, 1'b0);
    idle();
    #6;
    rst = 1'b1;
    #1;
    chk("t6_write_en", 32'(write_en), 32'd0);
    chk("t6_bank_sel", 32'(bank_sel), 32'd0);
    chk("t6_err_len", 32'(err_len), 32'd0);
    chk("t6_valid", 32'(rd_bank_valid), 32'd1);
    chk("t6_addr", 32'(addr_in_0), 32'd0);
    chk("t6_s_ready", 32'(s_ready), 32'd1);
    q.delete();
    exp_addr = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send(16'h0060 + 16'(i), i == 7, 1'b0);
    idle();
    idle();
    chk("t6_bank1_0", 32'(bank1[0]), 32'h60);
    chk("t6_bank1_7", 32'(bank1[7]), 32'h67);
    idle();
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    chk("final_wr_vs_acc", 32'(wr_cnt), 32'(acc_cnt));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
